// File: rtl/fma_ctrl_pkg.sv
// Shared encodings and helpers for the FMA issue arbiter: rounding modes,
// fflags layout and the per-operation tag carried alongside the FMA pipeline.
package fma_ctrl_pkg;

    localparam int unsigned RM_W     = 3;
    localparam int unsigned FFLAGS_W = 5;

    typedef enum logic [RM_W-1:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100,
        RM_DYN = 3'b111
    } rm_e;

    localparam int unsigned FLAG_NV = 4;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    typedef struct packed {
        logic valid;
        logic owner;
        logic illegal;
    } tag_t;

    localparam int unsigned TAG_W = $bits(tag_t);

    // DYN defers to the CSR frm value.
    function automatic logic [RM_W-1:0] rm_resolve(input logic [RM_W-1:0] req_rm,
                                                   input logic [RM_W-1:0] frm);
        return (req_rm == RM_DYN) ? frm : req_rm;
    endfunction

    // Reserved encodings after resolution trap instead of executing.
    function automatic logic rm_illegal(input logic [RM_W-1:0] rm);
        return (rm == 3'b101) || (rm == 3'b110) || (rm == 3'b111);
    endfunction

endpackage

// File: rtl/fma_rsp_fifo.sv
// First-word-fall-through response FIFO; read data forced to zero while empty.
module fma_rsp_fifo #(
    parameter int unsigned WIDTH = 38,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    assign valid  = (count != '0);
    assign do_pop = pop && valid;
    assign rdata  = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fma_issue_arbiter.sv
// Round-robin issue of two requesters into one fixed-latency FMA pipeline,
// with credit-based response FIFOs and sticky fflags accumulation.
module fma_issue_arbiter
    import fma_ctrl_pkg::*;
#(
    parameter int unsigned PARM_XLEN      = 32,
    parameter int unsigned PARM_RM        = 3,
    parameter int unsigned PARM_LAT       = 4,
    parameter int unsigned PARM_RSP_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               Req_valid_i,
    output logic [1:0]               Req_ready_o,
    input  logic [2*PARM_XLEN-1:0]   Req_A_i,
    input  logic [2*PARM_XLEN-1:0]   Req_B_i,
    input  logic [2*PARM_XLEN-1:0]   Req_C_i,
    input  logic [2*PARM_RM-1:0]     Req_rm_i,
    input  logic [PARM_RM-1:0]       Frm_i,
    output logic                     Fma_valid_o,
    output logic [PARM_XLEN-1:0]     Fma_A_o,
    output logic [PARM_XLEN-1:0]     Fma_B_o,
    output logic [PARM_XLEN-1:0]     Fma_C_o,
    output logic [PARM_RM-1:0]       Fma_rm_o,
    input  logic [PARM_XLEN-1:0]     Fma_result_i,
    input  logic [FFLAGS_W-1:0]      Fma_flags_i,
    output logic [1:0]               Rsp_valid_o,
    input  logic [1:0]               Rsp_ready_i,
    output logic [2*PARM_XLEN-1:0]   Rsp_result_o,
    output logic [2*FFLAGS_W-1:0]    Rsp_flags_o,
    output logic [1:0]               Rsp_illegal_o,
    output logic [FFLAGS_W-1:0]      Fflags_o,
    input  logic                     Fflags_clr_i
);

    localparam int unsigned CNT_W = $clog2(PARM_RSP_DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned RSP_W = PARM_XLEN + FFLAGS_W + 1;

    logic [1:0]          eligible;
    logic [1:0]          grant;
    logic                rr_ptr;
    logic                issue;
    logic                sel;
    logic                req_illegal;
    logic [PARM_RM-1:0]  rm_req;
    logic [PARM_RM-1:0]  rm_res;
    tag_t                tag_pipe [PARM_LAT+1];
    tag_t                exit_tag;
    logic [RSP_W-1:0]    exit_data;
    logic [FFLAGS_W-1:0] exit_flags;

    // Pointer only breaks ties; a lone eligible requester always wins.
    always_comb begin
        grant = '0;
        if (&eligible) grant[rr_ptr] = 1'b1;
        else           grant = eligible;
    end

    assign issue       = |grant;
    assign sel         = grant[1];
    assign Req_ready_o = grant;
    assign rm_req      = sel ? Req_rm_i[2*PARM_RM-1:PARM_RM] : Req_rm_i[PARM_RM-1:0];
    assign rm_res      = rm_resolve(rm_req, Frm_i);
    assign req_illegal = rm_illegal(rm_res);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= 1'b0;
            Fma_valid_o <= 1'b0;
            Fma_A_o     <= '0;
            Fma_B_o     <= '0;
            Fma_C_o     <= '0;
            Fma_rm_o    <= '0;
        end else begin
            Fma_valid_o <= issue && !req_illegal;
            if (issue) begin
                rr_ptr   <= ~sel;
                Fma_A_o  <= sel ? Req_A_i[2*PARM_XLEN-1:PARM_XLEN] : Req_A_i[PARM_XLEN-1:0];
                Fma_B_o  <= sel ? Req_B_i[2*PARM_XLEN-1:PARM_XLEN] : Req_B_i[PARM_XLEN-1:0];
                Fma_C_o  <= sel ? Req_C_i[2*PARM_XLEN-1:PARM_XLEN] : Req_C_i[PARM_XLEN-1:0];
                Fma_rm_o <= rm_res;
            end
        end
    end

    // Tag slot at index PARM_LAT lines up with Fma_result_i for its operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s <= PARM_LAT; s++) tag_pipe[s] <= '0;
        end else begin
            tag_pipe[0] <= '{valid: issue, owner: sel, illegal: req_illegal};
            for (int unsigned s = 1; s <= PARM_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
        end
    end

    assign exit_tag   = tag_pipe[PARM_LAT];
    assign exit_data  = exit_tag.illegal ? {{(PARM_XLEN+FFLAGS_W){1'b0}}, 1'b1}
                                         : {Fma_result_i, Fma_flags_i, 1'b0};
    assign exit_flags = (exit_tag.valid && !exit_tag.illegal) ? Fma_flags_i : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) Fflags_o <= '0;
        else        Fflags_o <= (Fflags_clr_i ? '0 : Fflags_o) | exit_flags;
    end

    for (genvar i = 0; i < 2; i++) begin : g_req
        logic [CNT_W-1:0] inflight;
        logic [CNT_W-1:0] fifo_count;
        logic             retire;
        logic             pop;
        logic [RSP_W-1:0] rsp_data;

        assign retire = exit_tag.valid && (exit_tag.owner == 1'(i));
        assign pop    = Rsp_valid_o[i] && Rsp_ready_i[i];

        // Credit covers both in-flight ops and queued responses so a push never overflows.
        assign eligible[i] = rst_n && Req_valid_i[i] &&
                             ((SUM_W'(inflight) + SUM_W'(fifo_count)) < SUM_W'(PARM_RSP_DEPTH));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                inflight <= '0;
            end else begin
                case ({grant[i], retire})
                    2'b10:   inflight <= inflight + CNT_W'(1);
                    2'b01:   inflight <= inflight - CNT_W'(1);
                    default: inflight <= inflight;
                endcase
            end
        end

        fma_rsp_fifo #(
            .WIDTH (RSP_W),
            .DEPTH (PARM_RSP_DEPTH),
            .CNT_W (CNT_W)
        ) u_rsp_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (retire),
            .wdata (exit_data),
            .pop   (pop),
            .valid (Rsp_valid_o[i]),
            .rdata (rsp_data),
            .count (fifo_count)
        );

        assign Rsp_result_o[i*PARM_XLEN +: PARM_XLEN] = rsp_data[RSP_W-1 -: PARM_XLEN];
        assign Rsp_flags_o[i*FFLAGS_W +: FFLAGS_W]    = rsp_data[FFLAGS_W:1];
        assign Rsp_illegal_o[i]                       = rsp_data[0];
    end

endmodule
